// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip memory.
// One transfer is accepted per cycle; reads return one cycle later to the issuing master.
module onchip_mem_arbiter #(
    parameter int unsigned DEPTH    = 5120,
    parameter int unsigned AW       = 13,
    parameter logic [31:0] OOB_DATA = 32'hDEADBEEF
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic [AW-1:0] m0_address,
    input  logic [3:0]    m0_byteenable,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [31:0]   m0_writedata,
    output logic          m0_waitrequest,
    output logic [31:0]   m0_readdata,
    output logic          m0_readdatavalid,

    input  logic [AW-1:0] m1_address,
    input  logic [3:0]    m1_byteenable,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [31:0]   m1_writedata,
    output logic          m1_waitrequest,
    output logic [31:0]   m1_readdata,
    output logic          m1_readdatavalid,

    output logic [AW-1:0] mem_address,
    output logic [3:0]    mem_byteenable,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    output logic          mem_clken,
    input  logic [31:0]   mem_readdata,

    output logic          oob_err,
    input  logic          oob_clr
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic          req0, req1;
    logic          gnt0, gnt1, granted;
    logic [AW-1:0] sel_address;
    logic [3:0]    sel_byteenable;
    logic [31:0]   sel_writedata;
    logic          sel_read, sel_write;
    logic          in_bounds;

    // last_grant_q holds the id of the most recently granted master (0 or 1)
    logic last_grant_q, last_grant_d;
    logic pend_valid_q, pend_valid_d;
    logic pend_id_q,    pend_id_d;
    logic pend_oob_q,   pend_oob_d;
    logic oob_err_q,    oob_err_d;

    always_comb begin
        req0    = m0_read | m0_write;
        req1    = m1_read | m1_write;
        gnt0    = req0 & (~req1 | last_grant_q);
        gnt1    = req1 & (~req0 | ~last_grant_q);
        granted = gnt0 | gnt1;
    end

    always_comb begin
        sel_address    = '0;
        sel_byteenable = '0;
        sel_writedata  = '0;
        sel_read       = 1'b0;
        sel_write      = 1'b0;
        if (gnt0) begin
            sel_address    = m0_address;
            sel_byteenable = m0_byteenable;
            sel_writedata  = m0_writedata;
            sel_read       = m0_read;
            sel_write      = m0_write;
        end else if (gnt1) begin
            sel_address    = m1_address;
            sel_byteenable = m1_byteenable;
            sel_writedata  = m1_writedata;
            sel_read       = m1_read;
            sel_write      = m1_write;
        end
        in_bounds = ({1'b0, sel_address} < DEPTH_W);
    end

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    assign mem_address    = sel_address;
    assign mem_byteenable = sel_byteenable;
    assign mem_writedata  = sel_writedata;
    assign mem_chipselect = granted & in_bounds;
    assign mem_write      = granted & sel_write & in_bounds;
    assign mem_clken      = 1'b1;

    // A combined read+write is treated as a write only, so it never queues a response
    always_comb begin
        last_grant_d = granted ? gnt1 : last_grant_q;
        pend_valid_d = granted & sel_read & ~sel_write;
        pend_id_d    = gnt1;
        pend_oob_d   = granted & ~in_bounds;
        oob_err_d    = oob_err_q;
        if (granted & ~in_bounds) begin
            oob_err_d = 1'b1;
        end else if (oob_clr) begin
            oob_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_id_q    <= 1'b0;
            pend_oob_q   <= 1'b0;
            oob_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            pend_oob_q   <= pend_oob_d;
            oob_err_q    <= oob_err_d;
        end
    end

    assign m0_readdatavalid = pend_valid_q & ~pend_id_q;
    assign m1_readdatavalid = pend_valid_q & pend_id_q;
    assign m0_readdata      = pend_oob_q ? OOB_DATA : mem_readdata;
    assign m1_readdata      = pend_oob_q ? OOB_DATA : mem_readdata;
    assign oob_err          = oob_err_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: behavioural RAM, round-robin reference model,
// directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_onchip_mem_arbiter;

    localparam int DEPTH = 5120;
    localparam int AW    = 13;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] m0_address, m1_address;
    logic [3:0]    m0_byteenable, m1_byteenable;
    logic          m0_read, m1_read, m0_write, m1_write;
    logic [31:0]   m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [31:0]   m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [31:0]   mem_writedata;
    logic [31:0]   mem_readdata;
    logic          oob_err, oob_clr;

    always #5 clk = ~clk;

    onchip_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .oob_err(oob_err), .oob_clr(oob_clr)
    );

    // On-chip RAM: registered read, byte-lane writes
    logic [31:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect && int'(mem_address) < DEPTH) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
            mem_readdata <= ram[mem_address];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [int];
    int          ref_last;
    logic        ref_oob;
    logic [32:0] exp_q[$];
    logic [31:0] obs_rd;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int id, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        if (id == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    task automatic idle();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        oob_clr = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        ref_last = 1;
        ref_oob  = 1'b0;
    endtask

    // One bus cycle: predict, check at the falling edge, then advance the model to the next edge
    task automatic step(output int g);
        logic          r0, r1, rd, wr, inb, has;
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   d, cur;
        logic [32:0]   e;
        int            k;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (r0 && r1)  g = (ref_last == 0) ? 1 : 0;
        else if (r0)   g = 0;
        else if (r1)   g = 1;
        else           g = -1;
        rd = 1'b0; wr = 1'b0; a = '0; be = '0; d = '0;
        if (g == 0) begin rd = m0_read; wr = m0_write; a = m0_address; be = m0_byteenable; d = m0_writedata; end
        if (g == 1) begin rd = m1_read; wr = m1_write; a = m1_address; be = m1_byteenable; d = m1_writedata; end
        k   = int'(a);
        inb = (k < DEPTH);

        @(negedge clk);
        if (r0) check("m0_waitrequest", m0_waitrequest, (g != 0));
        if (r1) check("m1_waitrequest", m1_waitrequest, (g != 1));
        check("mem_chipselect", mem_chipselect, (g >= 0) && inb);
        check("mem_write", mem_write, (g >= 0) && wr && inb);
        check("mem_clken", mem_clken, 1);
        if (g >= 0) begin
            check("mem_address", mem_address, a);
            check("mem_byteenable", mem_byteenable, be);
            if (wr) check("mem_writedata", mem_writedata, d);
        end
        has = (exp_q.size() != 0);
        e   = '0;
        if (has) e = exp_q.pop_front();
        check("m0_readdatavalid", m0_readdatavalid, has && !e[32]);
        check("m1_readdatavalid", m1_readdatavalid, has && e[32]);
        if (has) begin
            check("m0_readdata", m0_readdata, e[31:0]);
            check("m1_readdata", m1_readdata, e[31:0]);
        end
        obs_rd = m0_readdatavalid ? m0_readdata : m1_readdata;
        check("oob_err", oob_err, ref_oob);

        if (g >= 0) begin
            ref_last = g;
            if (wr) begin
                if (inb) begin
                    cur = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
                    end
                    ref_mem[k] = cur;
                end
            end else if (rd) begin
                cur = 32'hDEADBEEF;
                if (inb) cur = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
                exp_q.push_back({(g == 1), cur});
            end
        end
        if ((g >= 0) && !inb) ref_oob = 1'b1;
        else if (oob_clr)     ref_oob = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        check("rst_oob_err", oob_err, 0);
        check("rst_m0_rdv", m0_readdatavalid, 0);
        check("rst_m1_rdv", m1_readdatavalid, 0);
    endtask

    task automatic rand_m(input int id);
        int            k;
        logic [AW-1:0] a;
        k = $urandom_range(0, 9);
        if ($urandom_range(0, 5) == 0) a = AW'($urandom_range(DEPTH - 2, DEPTH + 5));
        else                           a = AW'($urandom_range(0, 31));
        set_m(id, (k >= 3 && k < 6) || k == 9, k >= 6, a, 4'($urandom_range(0, 15)), $urandom);
    endtask

    int   g;
    logic hold0, hold1;

    initial begin
        idle();
        do_reset();

        // Known contents for every address the random traffic can reach
        for (int i = 0; i < 32; i++) begin
            set_m(0, 1'b0, 1'b1, AW'(i), 4'hF, 32'h0); step(g);
        end
        set_m(0, 1'b0, 1'b1, 13'd5118, 4'hF, 32'h0); step(g);
        set_m(0, 1'b0, 1'b1, 13'd5119, 4'hF, 32'h0); step(g);
        idle(); step(g);

        // Write then read back on m0
        set_m(0, 1'b0, 1'b1, 13'h0010, 4'hF, 32'h12345678); step(g);
        set_m(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);        step(g);
        idle(); step(g);
        check("t1_readback", obs_rd, 32'h12345678);

        // Sustained conflict alternates grants from reset
        do_reset();
        set_m(0, 1'b1, 1'b0, 13'd1, 4'hF, 32'h0);
        set_m(1, 1'b1, 1'b0, 13'd2, 4'hF, 32'h0);
        repeat (4) step(g);
        idle(); step(g);

        // Byte-lane write
        set_m(0, 1'b0, 1'b1, 13'd7, 4'hF, 32'h0);         step(g);
        set_m(0, 1'b0, 1'b1, 13'd7, 4'b0101, 32'hAABBCCDD); step(g);
        set_m(0, 1'b1, 1'b0, 13'd7, 4'hF, 32'h0);         step(g);
        idle(); step(g);
        check("t3_bytelanes", obs_rd, 32'h00BB00DD);

        // Out-of-bounds access and sticky flag
        set_m(1, 1'b0, 1'b1, 13'd5120, 4'hF, 32'hCAFEF00D); step(g);
        set_m(1, 1'b1, 1'b0, 13'd5120, 4'hF, 32'h0);        step(g);
        idle(); step(g);
        check("t4_oob_data", obs_rd, 32'hDEADBEEF);
        check("t4_oob_set", oob_err, 1);
        oob_clr = 1'b1; step(g);
        idle(); step(g);
        check("t4_oob_clr", oob_err, 0);
        oob_clr = 1'b1;
        set_m(1, 1'b1, 1'b0, 13'd5120, 4'hF, 32'h0); step(g);
        idle(); step(g);
        check("t4_oob_set_wins", oob_err, 1);

        // Reset lands on an accepted read
        set_m(0, 1'b1, 1'b0, 13'd1, 4'hF, 32'h0);
        @(negedge clk);
        check("t5_accept", m0_waitrequest, 0);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1;
        idle();
        reset_n = 1'b1;
        model_reset();
        step(g);
        set_m(0, 1'b1, 1'b0, 13'd2, 4'hF, 32'h0);
        set_m(1, 1'b1, 1'b0, 13'd3, 4'hF, 32'h0);
        step(g);
        idle(); step(g);

        // Simultaneous read and write from one master
        set_m(0, 1'b1, 1'b1, 13'd3, 4'hF, 32'h00000055); step(g);
        idle(); step(g);
        set_m(0, 1'b1, 1'b0, 13'd3, 4'hF, 32'h0); step(g);
        idle(); step(g);
        check("t6_rw_readback", obs_rd, 32'h00000055);

        // Randomized traffic; a waiting master holds its request until accepted
        hold0 = 1'b0;
        hold1 = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!hold0) rand_m(0);
            if (!hold1) rand_m(1);
            oob_clr = ($urandom_range(0, 7) == 0);
            step(g);
            hold0 = (m0_read | m0_write) && (g != 0);
            hold1 = (m1_read | m1_write) && (g != 1);
        end
        idle(); step(g);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master round-robin arbiter that shares the Nios single-port on-chip memory (5120 x 32-bit words, 13-bit word address, byte enables, 1-cycle read latency) between two Avalon-MM masters (CPU data port and DMA).
- Sits between the masters and the memory slave.
- Drives the memory's address, byteenable, chipselect, write, writedata and clken.
- Returns read data with readdatavalid to the master that issued the read.

Parameters:
- DEPTH, 5120, number of valid 32-bit words; word addresses >= DEPTH are out-of-bounds.
- AW, 13, word address width.
- OOB_DATA, 32'hDEADBEEF, read data returned for an out-of-bounds read.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_address / m1_address  in  AW  master word address.
- m0_byteenable / m1_byteenable  in  4  byte lanes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  32  write data.
- m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle.
- m0_readdata / m1_readdata  out  32  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle strobe qualifying readdata.
- mem_address  out  AW  to memory.
- mem_byteenable  out  4  to memory.
- mem_chipselect  out  1  to memory.
- mem_write  out  1  to memory.
- mem_writedata  out  32  to memory.
- mem_clken  out  1  memory clock enable; constant 1.
- mem_readdata  in  32  memory output, valid the cycle after the address is presented.
- oob_err  out  1  sticky out-of-bounds flag.
- oob_clr  in  1  synchronous clear of oob_err.

Behaviour:
- Request: reqX = mX_read | mX_write.
- Grant is combinational each cycle:
  - Only one master requesting: that master is granted.
  - Both requesting: the master not recorded in last_grant is granted.
- last_grant register:
  - Updates to the granted master on every cycle with a grant.
  - Holds when idle.
  - Reset value = 1, so m0 wins the first conflict.
- Waitrequest:
  - The granted master sees waitrequest = 0.
  - A requesting master that is not granted sees waitrequest = 1.
  - A master that is not requesting sees waitrequest = 1 (don't-care for masters).
  - A master holds its request stable until waitrequest = 0; the arbiter does not check this.
- Memory drive:
  - mem_address, mem_byteenable and mem_writedata mux combinationally from the granted master; all zero when there is no grant.
  - mem_write = granted mX_write & in-bounds.
  - mem_chipselect = grant & in-bounds.
- Read pipeline:
  - A read accepted in cycle N is registered as (pend_valid, pend_id, pend_oob).
  - In cycle N+1, mX_readdatavalid = 1 for X = pend_id only.
  - mX_readdata = mem_readdata, or OOB_DATA when pend_oob.
  - Both readdata buses carry the same value; only the valid strobe differs.
  - Back-to-back reads, including alternating masters, are supported at 1 per cycle: one request accepted per cycle, throughput 1 per cycle.
- Write: completes in the accept cycle; no response is generated.
- Read and write asserted together by one master:
  - The write is performed.
  - The read is ignored: no readdatavalid is produced.
  - The grant counts as a single transfer.
- Out-of-bounds (address >= DEPTH):
  - The memory is not selected.
  - A write is dropped but still accepted (waitrequest = 0).
  - A read returns OOB_DATA with normal 1-cycle latency.
  - oob_err is set the cycle after the access.
- oob_err behaviour:
  - oob_clr clears it.
  - If a new OOB access occurs in the same cycle as oob_clr, the set wins.
- Reset (asynchronous):
  - last_grant = 1.
  - pend_valid = 0, pend_id = 0, pend_oob = 0.
  - oob_err = 0.
  - All readdatavalid = 0.
  - A read accepted in the cycle reset asserts gets no readdatavalid after reset.
  - Reset deasserts synchronously to clk externally; the first grant is possible in the first cycle after deassertion.

Test Plan:
1. m0 writes 0x12345678 to addr 0x0010 with byteenable 4'hF; next cycle m0 reads 0x0010 -> m0_waitrequest = 0 both cycles; in the following cycle m0_readdatavalid = 1, m0_readdata = 0x12345678, m1_readdatavalid = 0.
2. m0 and m1 both hold reads (addr 1, addr 2) for 4 cycles after reset -> grants go m0, m1, m0, m1; readdatavalid alternates m0/m1 one cycle later with the correct data; the waiting master sees waitrequest = 1 each alternate cycle.
3. Byte-lane write of 0xAABBCCDD with byteenable 4'b0101 to a word holding 0 -> readback 0x00BB00DD.
4. m1 writes to addr 5120, then reads 5120 -> memory not selected (mem_chipselect = 0); read returns 0xDEADBEEF; oob_err = 1. Then oob_clr pulse -> oob_err = 0. Then oob_clr together with another OOB access -> oob_err stays 1.
5. m0 read accepted, reset_n pulsed low in the same cycle -> no readdatavalid after reset; next conflict goes to m0.
6. m0 asserts read and write together with data 0x55 at addr 3 -> no readdatavalid; a subsequent read of addr 3 returns 0x00000055.
